rename_register_file: RTL and testbench
=======================================

# rename_register_file

Architectural register file with per-register rename tags. It answers the reservation station's operand/rename query one cycle after issue and records the new instruction's destination rename. It also retires values committed by the ROB and clears all rename state on a predictor flush. It sits between the reservation station (query side) and the ROB commit port.

## Interface
- `ROB_TAG_W`, default 4: ROB/rename tag width.
- `NUM_REGS`, default 32: architectural registers; x0 hardwired zero.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global enable; low = hold everything.
- `rename_need`  in  1  RS query valid.
- `rename_need_id`  in  4  RS slot being filled; echoed back.
- `operand_1_flag`, `operand_2_flag`  in  1 each  operand lookup requested.
- `operand_1_reg`, `operand_2_reg`  in  5 each  source register indices.
- `new_ins_rd`  in  5  destination register of the issuing instruction.
- `new_ins_rd_rename`  in  4  ROB tag for that destination.
- `commit_flag`  in  1  ROB commit valid.
- `commit_reg`  in  5  committed destination register.
- `commit_rename`  in  4  committed ROB tag.
- `commit_value`  in  32  committed value.
- `rf_flush`  in  1  misprediction flush.
- `rename_finish`  out  1  response valid.
- `rename_finish_id`  out  4  echoed RS slot.
- `operand_1_busy`, `operand_2_busy`  out  1 each  operand awaits a ROB result.
- `operand_1_rename`, `operand_2_rename`  out  4 each  producing ROB tag when busy.
- `operand_1_data_from_reg`, `operand_2_data_from_reg`  out  32 each  value when not busy.

## Operation
- State per register: `value[31:0]`, `busy`, `tag[3:0]`. x0: value 0, never busy, writes and renames ignored.
- Query lookup for operand k, evaluated on the cycle `rename_need`=1:
  - If flag=0 or reg=0, return busy=0, rename=0, data=0.
  - Otherwise, if the register is not busy, return busy=0 and the stored value.
  - Otherwise, if it is busy and `commit_flag` holds the same register and a matching tag this cycle (bypass), return busy=0 and `commit_value`.
  - Otherwise return busy=1 and the stored tag, with data=0.
- Lookup reads the mapping before this query's own rd rename. `addi x1,x1,1` sees the previous producer of x1.
- Rename: when `rename_need`=1 and `new_ins_rd`≠0, set busy=1 and tag=`new_ins_rd_rename`.
- Commit: when `commit_flag`=1 and `commit_reg`≠0, write the value. Clear busy only if the stored tag equals `commit_rename`; a stale commit leaves busy and tag untouched.
- Same-cycle rename and commit to one register: value written, busy stays 1, tag takes the new rename.
- Flush: clear every busy bit, values untouched. A commit in the flush cycle still writes its value. A query in the flush cycle is dropped: no rename recorded, `rename_finish`=0 next cycle.
- No query: `rename_finish` is 0 next cycle; the other response outputs hold their last values.

## Timing
- Query at edge N yields response registered at edge N+1, with `rename_finish`=1 for exactly one cycle per query.
- Back-to-back queries give back-to-back responses. Query N+1 sees the rd rename from query N.
- Commit takes effect at the same edge; a lookup in the following cycle sees the updated state.
- `rdy`=0: no state or output changes, inputs ignored.
- Reset (asynchronous, any time): every output is 0; all values 0, all busy 0, all tags 0. A response in flight is lost.

## Configuration
- `RF_DEBUG_PORT_EN`
  - Defined: adds input `dbg_reg_sel[4:0]` and output `dbg_reg_data[31:0]`, a combinational read of the architectural value for simulation and test.
  - Undefined: the ports are absent and the function is unchanged.

## Structure
- Shared package `riscv_cpu_pkg` holds `XLEN`=32, `REG_IDX_W`=5, `ROB_TAG_W`=4, and the `rf_entry_t` struct {value, busy, tag}.
- Sub-module `rf_operand_lookup` implements the combinational per-operand lookup with commit bypass. It is instantiated twice.

## Test plan
- **Basic rename then read.** Reset; query rd=x5 tag 3 with no operands; then query op1=x5. Required response: busy=1, rename=3.
- **Bypass.** x5 busy with tag 3; in one cycle, query op1=x5 and commit x5/tag 3/value 0x1234. Required response: busy=0, data=0x1234; x5 is then not busy.
- **Stale commit.** x5 renamed to tag 3, then to tag 7; commit x5/tag 3/value 9. Required: x5 stays busy with tag 7, stored value 9.
- **Self-read.** x1=0x10 committed; query op1=x1, rd=x1, tag 2. Required response: busy=0, data=0x10; the next query of x1 returns busy=1, rename=2.
- **Flush with query.** Several registers busy; assert `rf_flush` together with a query. Required: `rename_finish`=0 next cycle, all registers not busy, values preserved.
- **x0 and `rdy`.** Query rd=x0 and op1=x0. Required response: busy=0, data=0, and x0 never becomes busy. Holding `rdy`=0 across a query freezes all outputs.

Source files
------------

// File: rtl/riscv_cpu_pkg.sv
// Shared CPU constants and the architectural register entry layout.
package riscv_cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ROB_TAG_W = 4;
    localparam int unsigned RS_ID_W   = 4;

    typedef struct packed {
        logic [XLEN-1:0]      value;
        logic                 busy;
        logic [ROB_TAG_W-1:0] tag;
    } rf_entry_t;

endpackage

// File: rtl/rf_operand_lookup.sv
// Combinational lookup of one source operand, with same-cycle bypass from the ROB commit port.
module rf_operand_lookup #(
    parameter int unsigned ROB_TAG_W = riscv_cpu_pkg::ROB_TAG_W
) (
    input  logic                                  flag,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   reg_idx,
    input  logic                                  reg_busy,
    input  logic [ROB_TAG_W-1:0]                  reg_tag,
    input  logic [riscv_cpu_pkg::XLEN-1:0]        reg_value,
    input  logic                                  commit_flag,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   commit_reg,
    input  logic [ROB_TAG_W-1:0]                  commit_rename,
    input  logic [riscv_cpu_pkg::XLEN-1:0]        commit_value,
    output logic                                  busy,
    output logic [ROB_TAG_W-1:0]                  rename,
    output logic [riscv_cpu_pkg::XLEN-1:0]        data
);

    logic bypass_hit;

    assign bypass_hit = commit_flag && (commit_reg == reg_idx) && (commit_rename == reg_tag);

    always_comb begin
        busy   = 1'b0;
        rename = '0;
        data   = '0;
        if (flag && (reg_idx != '0)) begin
            if (!reg_busy) begin
                data = reg_value;
            end else if (bypass_hit) begin
                data = commit_value;
            end else begin
                busy   = 1'b1;
                rename = reg_tag;
            end
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags, ROB commit and flush.
// Optional RF_DEBUG_PORT_EN adds a combinational debug read port (dbg_reg_sel/dbg_reg_data).
module rename_register_file #(
    parameter int unsigned ROB_TAG_W = riscv_cpu_pkg::ROB_TAG_W,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rdy,
    input  logic                                  rename_need,
    input  logic [riscv_cpu_pkg::RS_ID_W-1:0]     rename_need_id,
    input  logic                                  operand_1_flag,
    input  logic                                  operand_2_flag,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   operand_1_reg,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   operand_2_reg,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   new_ins_rd,
    input  logic [ROB_TAG_W-1:0]                  new_ins_rd_rename,
    input  logic                                  commit_flag,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   commit_reg,
    input  logic [ROB_TAG_W-1:0]                  commit_rename,
    input  logic [riscv_cpu_pkg::XLEN-1:0]        commit_value,
    input  logic                                  rf_flush,
    output logic                                  rename_finish,
    output logic [riscv_cpu_pkg::RS_ID_W-1:0]     rename_finish_id,
    output logic                                  operand_1_busy,
    output logic                                  operand_2_busy,
    output logic [ROB_TAG_W-1:0]                  operand_1_rename,
    output logic [ROB_TAG_W-1:0]                  operand_2_rename,
    output logic [riscv_cpu_pkg::XLEN-1:0]        operand_1_data_from_reg,
    output logic [riscv_cpu_pkg::XLEN-1:0]        operand_2_data_from_reg
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [riscv_cpu_pkg::REG_IDX_W-1:0]   dbg_reg_sel,
    output logic [riscv_cpu_pkg::XLEN-1:0]        dbg_reg_data
`endif
);

    localparam int unsigned XLEN      = riscv_cpu_pkg::XLEN;
    localparam int unsigned REG_IDX_W = riscv_cpu_pkg::REG_IDX_W;

    logic [XLEN-1:0]      value_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [ROB_TAG_W-1:0] tag_q   [NUM_REGS];

    logic                 op1_busy, op2_busy;
    logic [ROB_TAG_W-1:0] op1_rename, op2_rename;
    logic [XLEN-1:0]      op1_data, op2_data;
    logic                 query_accept;

    // A query coinciding with a flush belongs to the squashed path and is dropped.
    assign query_accept = rename_need && !rf_flush;

    rf_operand_lookup #(
        .ROB_TAG_W (ROB_TAG_W)
    ) u_lookup_op1 (
        .flag          (operand_1_flag),
        .reg_idx       (operand_1_reg),
        .reg_busy      (busy_q[operand_1_reg]),
        .reg_tag       (tag_q[operand_1_reg]),
        .reg_value     (value_q[operand_1_reg]),
        .commit_flag   (commit_flag),
        .commit_reg    (commit_reg),
        .commit_rename (commit_rename),
        .commit_value  (commit_value),
        .busy          (op1_busy),
        .rename        (op1_rename),
        .data          (op1_data)
    );

    rf_operand_lookup #(
        .ROB_TAG_W (ROB_TAG_W)
    ) u_lookup_op2 (
        .flag          (operand_2_flag),
        .reg_idx       (operand_2_reg),
        .reg_busy      (busy_q[operand_2_reg]),
        .reg_tag       (tag_q[operand_2_reg]),
        .reg_value     (value_q[operand_2_reg]),
        .commit_flag   (commit_flag),
        .commit_reg    (commit_reg),
        .commit_rename (commit_rename),
        .commit_value  (commit_value),
        .busy          (op2_busy),
        .rename        (op2_rename),
        .data          (op2_data)
    );

    // Register state. Entry 0 is never written, so x0 stays zero and never busy.
    // Ordering inside a register: commit clear, then flush, then the new rename wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit_flag && (commit_reg == REG_IDX_W'(i))) begin
                    value_q[i] <= commit_value;
                    if (tag_q[i] == commit_rename) begin
                        busy_q[i] <= 1'b0;
                    end
                end
                if (rf_flush) begin
                    busy_q[i] <= 1'b0;
                end else if (rename_need && (new_ins_rd == REG_IDX_W'(i))) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= new_ins_rd_rename;
                end
            end
        end
    end

    // Response registers; payload holds its last value when no query is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rename_finish           <= 1'b0;
            rename_finish_id        <= '0;
            operand_1_busy          <= 1'b0;
            operand_2_busy          <= 1'b0;
            operand_1_rename        <= '0;
            operand_2_rename        <= '0;
            operand_1_data_from_reg <= '0;
            operand_2_data_from_reg <= '0;
        end else if (rdy) begin
            rename_finish <= query_accept;
            if (query_accept) begin
                rename_finish_id        <= rename_need_id;
                operand_1_busy          <= op1_busy;
                operand_2_busy          <= op2_busy;
                operand_1_rename        <= op1_rename;
                operand_2_rename        <= op2_rename;
                operand_1_data_from_reg <= op1_data;
                operand_2_data_from_reg <= op2_data;
            end
        end
    end

`ifdef RF_DEBUG_PORT_EN
    assign dbg_reg_data = value_q[dbg_reg_sel];
`endif

endmodule

// File: tb/tb_rename_register_file.sv
// Self-checking bench for rename_register_file: directed scenarios plus randomized traffic.
module tb_rename_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy;
    logic        rename_need;
    logic [3:0]  rename_need_id;
    logic        operand_1_flag, operand_2_flag;
    logic [4:0]  operand_1_reg, operand_2_reg;
    logic [4:0]  new_ins_rd;
    logic [3:0]  new_ins_rd_rename;
    logic        commit_flag;
    logic [4:0]  commit_reg;
    logic [3:0]  commit_rename;
    logic [31:0] commit_value;
    logic        rf_flush;
    logic        rename_finish;
    logic [3:0]  rename_finish_id;
    logic        operand_1_busy, operand_2_busy;
    logic [3:0]  operand_1_rename, operand_2_rename;
    logic [31:0] operand_1_data_from_reg, operand_2_data_from_reg;
`ifdef RF_DEBUG_PORT_EN
    logic [4:0]  dbg_reg_sel = '0;
    logic [31:0] dbg_reg_data;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: architectural view of each register.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    // Expected registered response.
    logic        e_fin;
    logic [3:0]  e_id;
    logic        e_b1, e_b2;
    logic [3:0]  e_r1, e_r2;
    logic [31:0] e_d1, e_d2;

    rename_register_file dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .rename_need             (rename_need),
        .rename_need_id          (rename_need_id),
        .operand_1_flag          (operand_1_flag),
        .operand_2_flag          (operand_2_flag),
        .operand_1_reg           (operand_1_reg),
        .operand_2_reg           (operand_2_reg),
        .new_ins_rd              (new_ins_rd),
        .new_ins_rd_rename       (new_ins_rd_rename),
        .commit_flag             (commit_flag),
        .commit_reg              (commit_reg),
        .commit_rename           (commit_rename),
        .commit_value            (commit_value),
        .rf_flush                (rf_flush),
        .rename_finish           (rename_finish),
        .rename_finish_id        (rename_finish_id),
        .operand_1_busy          (operand_1_busy),
        .operand_2_busy          (operand_2_busy),
        .operand_1_rename        (operand_1_rename),
        .operand_2_rename        (operand_2_rename),
        .operand_1_data_from_reg (operand_1_data_from_reg),
        .operand_2_data_from_reg (operand_2_data_from_reg)
`ifdef RF_DEBUG_PORT_EN
        ,
        .dbg_reg_sel             (dbg_reg_sel),
        .dbg_reg_data            (dbg_reg_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, ".fin"}, 32'(rename_finish), 32'(e_fin));
        check({where, ".id"},  32'(rename_finish_id), 32'(e_id));
        check({where, ".b1"},  32'(operand_1_busy), 32'(e_b1));
        check({where, ".r1"},  32'(operand_1_rename), 32'(e_r1));
        check({where, ".d1"},  operand_1_data_from_reg, e_d1);
        check({where, ".b2"},  32'(operand_2_busy), 32'(e_b2));
        check({where, ".r2"},  32'(operand_2_rename), 32'(e_r2));
        check({where, ".d2"},  operand_2_data_from_reg, e_d2);
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = '0;
            m_busy[i] = 1'b0;
            m_tag[i]  = '0;
        end
        e_fin = 0; e_id = 0; e_b1 = 0; e_b2 = 0;
        e_r1 = 0; e_r2 = 0; e_d1 = 0; e_d2 = 0;
    endfunction

    // What the register file should report for one operand, given the present inputs.
    function automatic void lookup(input logic f, input logic [4:0] r, output logic b,
                                   output logic [3:0] t, output logic [31:0] d);
        b = 0; t = 0; d = 0;
        if (f && r != 0) begin
            if (!m_busy[r]) d = m_val[r];
            else if (commit_flag && commit_reg == r && commit_rename == m_tag[r]) d = commit_value;
            else begin
                b = 1;
                t = m_tag[r];
            end
        end
    endfunction

    task automatic idle();
        rdy = 1; rename_need = 0; rename_need_id = 0;
        operand_1_flag = 0; operand_2_flag = 0; operand_1_reg = 0; operand_2_reg = 0;
        new_ins_rd = 0; new_ins_rd_rename = 0;
        commit_flag = 0; commit_reg = 0; commit_rename = 0; commit_value = 0;
        rf_flush = 0;
    endtask

    task automatic query(input logic [3:0] id, input logic f1, input logic [4:0] r1,
                         input logic f2, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [3:0] tag);
        rename_need = 1; rename_need_id = id;
        operand_1_flag = f1; operand_1_reg = r1;
        operand_2_flag = f2; operand_2_reg = r2;
        new_ins_rd = rd; new_ins_rd_rename = tag;
    endtask

    task automatic commit(input logic [4:0] r, input logic [3:0] tag, input logic [31:0] v);
        commit_flag = 1; commit_reg = r; commit_rename = tag; commit_value = v;
    endtask

    // One clock: derive expected response and next model state, clock, then compare.
    task automatic do_cycle(input string where);
        if (rdy) begin
            e_fin = rename_need && !rf_flush;
            if (e_fin) begin
                e_id = rename_need_id;
                lookup(operand_1_flag, operand_1_reg, e_b1, e_r1, e_d1);
                lookup(operand_2_flag, operand_2_reg, e_b2, e_r2, e_d2);
            end
            if (commit_flag && commit_reg != 0) begin
                m_val[commit_reg] = commit_value;
                if (m_tag[commit_reg] == commit_rename) m_busy[commit_reg] = 0;
            end
            if (rf_flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (rename_need && new_ins_rd != 0) begin
                m_busy[new_ins_rd] = 1;
                m_tag[new_ins_rd]  = new_ins_rd_rename;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(where);
    endtask

    task automatic apply_reset(input string where);
        rst = 1;
        #2;
        model_clear();
        check_outputs(where);
        #2;
        rst = 0;
    endtask

    initial begin
        idle();
        apply_reset("reset");
        @(negedge clk);

        // Basic rename then read
        query(4'd1, 0, 0, 0, 0, 5'd5, 4'd3);
        do_cycle("basic_rn");
        check("basic_fin", 32'(rename_finish), 1);
        idle(); query(4'd2, 1, 5'd5, 0, 0, 0, 0);
        do_cycle("basic_rd");
        check("basic_busy", 32'(operand_1_busy), 1);
        check("basic_tag", 32'(operand_1_rename), 3);

        // Bypass from a matching commit
        idle(); query(4'd3, 1, 5'd5, 0, 0, 0, 0); commit(5'd5, 4'd3, 32'h1234);
        do_cycle("bypass");
        check("bypass_busy", 32'(operand_1_busy), 0);
        check("bypass_data", operand_1_data_from_reg, 32'h1234);
        idle(); query(4'd4, 1, 5'd5, 0, 0, 0, 0);
        do_cycle("bypass_after");
        check("bypass_after_busy", 32'(operand_1_busy), 0);

        // Stale commit leaves the newer rename in place
        idle(); query(4'd5, 0, 0, 0, 0, 5'd5, 4'd3); do_cycle("stale_rn3");
        idle(); query(4'd6, 0, 0, 0, 0, 5'd5, 4'd7); do_cycle("stale_rn7");
        idle(); commit(5'd5, 4'd3, 32'd9); do_cycle("stale_commit");
`ifdef RF_DEBUG_PORT_EN
        dbg_reg_sel = 5'd5;
        #1;
        check("stale_dbg_value", dbg_reg_data, 32'd9);
`endif
        idle(); query(4'd7, 1, 5'd5, 0, 0, 0, 0); do_cycle("stale_rd");
        check("stale_busy", 32'(operand_1_busy), 1);
        check("stale_tag", 32'(operand_1_rename), 7);

        // Self-read: lookup precedes own rename
        idle(); commit(5'd1, 4'd0, 32'h10); do_cycle("self_commit");
        idle(); query(4'd8, 1, 5'd1, 0, 0, 5'd1, 4'd2); do_cycle("self_rd");
        check("self_busy", 32'(operand_1_busy), 0);
        check("self_data", operand_1_data_from_reg, 32'h10);
        idle(); query(4'd9, 1, 5'd1, 0, 0, 0, 0); do_cycle("self_next");
        check("self_next_busy", 32'(operand_1_busy), 1);
        check("self_next_tag", 32'(operand_1_rename), 2);

        // Flush with a query: dropped, busy cleared, values kept
        idle(); query(4'd10, 1, 5'd1, 1, 5'd5, 5'd4, 4'd6); rf_flush = 1;
        do_cycle("flush");
        check("flush_fin", 32'(rename_finish), 0);
        idle(); query(4'd11, 1, 5'd1, 1, 5'd5, 0, 0); do_cycle("flush_vals");
        check("flush_b1", 32'(operand_1_busy), 0);
        check("flush_d1", operand_1_data_from_reg, 32'h10);
        check("flush_b2", 32'(operand_2_busy), 0);
        check("flush_d2", operand_2_data_from_reg, 32'd9);
        idle(); query(4'd12, 1, 5'd4, 0, 0, 0, 0); do_cycle("flush_norn");
        check("flush_no_rename", 32'(operand_1_busy), 0);

        // x0 is never renamed
        idle(); query(4'd4, 1, 5'd0, 0, 0, 5'd0, 4'd9); do_cycle("x0_q");
        check("x0_busy", 32'(operand_1_busy), 0);
        check("x0_data", operand_1_data_from_reg, 0);
        idle(); query(4'd4, 1, 5'd0, 0, 0, 0, 0); do_cycle("x0_again");
        check("x0_never_busy", 32'(operand_1_busy), 0);

        // rdy low freezes outputs and ignores the query
        idle(); rdy = 0; query(4'd13, 1, 5'd1, 0, 0, 5'd6, 4'd1); commit(5'd6, 4'd0, 32'h55);
        do_cycle("rdy_low");
        check("rdy_fin_hold", 32'(rename_finish), 1);
        check("rdy_id_hold", 32'(rename_finish_id), 4);
        idle(); query(4'd14, 1, 5'd6, 0, 0, 0, 0); do_cycle("rdy_after");
        check("rdy_no_rename", 32'(operand_1_busy), 0);
        check("rdy_no_write", operand_1_data_from_reg, 0);

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (n == 700) begin
                idle();
                apply_reset("mid_reset");
            end
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 6)
                query(4'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                commit_reg = 5'($urandom_range(0, 7));
                commit(commit_reg,
                       ($urandom_range(0, 9) < 7) ? m_tag[commit_reg] : 4'($urandom),
                       $urandom);
            end
            rf_flush = ($urandom_range(0, 19) == 0);
            do_cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
